// File: rtl/regwr_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regwr_arbiter_pkg;
  localparam int N_REGS = 8;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  typedef logic [REG_AW-1:0] reg_addr_t;

  function automatic logic [N_REGS-1:0] onehot(input reg_addr_t addr);
    logic [N_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction
endpackage

// File: rtl/regwr_arbiter_if.sv
// Requester handshakes, stall and register-file write/read-check signals.
interface regwr_arbiter_if;
  import regwr_arbiter_pkg::*;

  logic                a_valid;
  reg_addr_t           a_addr;
  logic [DATA_W-1:0]   a_data;
  logic                a_ready;
  logic                b_valid;
  reg_addr_t           b_addr;
  logic [DATA_W-1:0]   b_data;
  logic                b_ready;
  logic                wr_stall;
  logic [N_REGS-1:0]   reg_wr_en;
  logic [DATA_W-1:0]   reg_wr_data;
  reg_addr_t           rd_addr;
  logic                rd_pending;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, wr_stall, rd_addr,
    input  a_ready, b_ready, reg_wr_en, reg_wr_data, rd_pending
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, wr_stall, rd_addr,
    output a_ready, b_ready, reg_wr_en, reg_wr_data, rd_pending
  );
endinterface

// File: rtl/regwr_arbiter_rr_arb2.sv
// Combinational 2-way round-robin arbiter; req/gnt bit 0 is A, bit 1 is B.
module rr_arb2
  import regwr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last,
  input  logic       en,
  output logic [1:0] gnt
);
  // On a tie the side that did not win last time gets the port.
  assign gnt[0] = en && req[0] && (!req[1] || (last == GRANT_B));
  assign gnt[1] = en && req[1] && (!req[0] || (last == GRANT_A));
endmodule

// File: rtl/regwr_arbiter.sv
// Write-port arbiter and one-entry issue stage for the 8 x 16-bit register file.
// Optional conflict counter enabled by defining REGWR_ARBITER_CONFLICT_CNT_EN.
module regwr_arbiter
  import regwr_arbiter_pkg::*;
(
  input logic             clk,
  input logic             rst,
  regwr_arbiter_if.slave  bus
`ifdef REGWR_ARBITER_CONFLICT_CNT_EN
  ,
  output logic [15:0]     conflict_cnt
`endif
);
  grant_e            last_grant;
  logic              iss_vld;
  reg_addr_t         iss_addr;
  logic [DATA_W-1:0] iss_data;
  logic [1:0]        gnt;
  logic              arb_en;

  assign arb_en = rst && !bus.wr_stall;

  rr_arb2 u_rr_arb2 (
    .req  ({bus.b_valid, bus.a_valid}),
    .last (last_grant),
    .en   (arb_en),
    .gnt  (gnt)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];

  // Grants only happen when not stalled, so loading never overruns a held write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      iss_vld    <= 1'b0;
      iss_addr   <= '0;
      iss_data   <= '0;
      last_grant <= GRANT_B;
    end else if (gnt[0]) begin
      iss_vld    <= 1'b1;
      iss_addr   <= bus.a_addr;
      iss_data   <= bus.a_data;
      last_grant <= GRANT_A;
    end else if (gnt[1]) begin
      iss_vld    <= 1'b1;
      iss_addr   <= bus.b_addr;
      iss_data   <= bus.b_data;
      last_grant <= GRANT_B;
    end else if (!bus.wr_stall) begin
      iss_vld    <= 1'b0;
    end
  end

  // Gating with rst keeps a write caught by reset from reaching the register file.
  assign bus.reg_wr_en   = (rst && iss_vld && !bus.wr_stall) ? onehot(iss_addr) : '0;
  assign bus.reg_wr_data = iss_data;
  assign bus.rd_pending  = rst && iss_vld && (iss_addr == bus.rd_addr);

`ifdef REGWR_ARBITER_CONFLICT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (bus.a_valid && bus.b_valid && !bus.wr_stall && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_regwr_arbiter.sv
// Bench for regwr_arbiter: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural write-port model.
module tb_regwr_arbiter;
  import regwr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  regwr_arbiter_if bus ();
`ifdef REGWR_ARBITER_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  regwr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef REGWR_ARBITER_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the pending write, who won last, and the resulting register file.
  logic              m_vld    = 1'b0;
  reg_addr_t         m_addr   = '0;
  logic [DATA_W-1:0] m_data   = '0;
  logic              m_last_b = 1'b1;
  logic [15:0]       m_cnt    = '0;
  logic [DATA_W-1:0] m_regs [N_REGS];
  logic [DATA_W-1:0] d_regs [N_REGS];

  initial begin
    for (int i = 0; i < N_REGS; i++) begin
      m_regs[i] = '0;
      d_regs[i] = '0;
    end
  end

  always @(negedge clk) begin
    logic a_win, b_win;
    logic [N_REGS-1:0] exp_en;
    a_win  = rst && !bus.wr_stall && bus.a_valid && (!bus.b_valid || m_last_b);
    b_win  = rst && !bus.wr_stall && bus.b_valid && (!bus.a_valid || !m_last_b);
    exp_en = '0;
    if (rst && m_vld && !bus.wr_stall) exp_en = N_REGS'(1) << m_addr;

    chk("a_ready", 32'(bus.a_ready), 32'(a_win));
    chk("b_ready", 32'(bus.b_ready), 32'(b_win));
    chk("reg_wr_en", 32'(bus.reg_wr_en), 32'(exp_en));
    chk("reg_wr_data", 32'(bus.reg_wr_data), 32'(m_data));
    chk("rd_pending", 32'(bus.rd_pending), 32'(rst && m_vld && (m_addr == bus.rd_addr)));
`ifdef REGWR_ARBITER_CONFLICT_CNT_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`endif

    for (int i = 0; i < N_REGS; i++)
      if (bus.reg_wr_en[i]) d_regs[i] = bus.reg_wr_data;

    if (!rst) begin
      m_vld = 1'b0; m_addr = '0; m_data = '0; m_last_b = 1'b1; m_cnt = '0;
    end else begin
      if (exp_en != '0) m_regs[m_addr] = m_data;
      if (a_win) begin
        m_vld = 1'b1; m_addr = bus.a_addr; m_data = bus.a_data; m_last_b = 1'b0;
      end else if (b_win) begin
        m_vld = 1'b1; m_addr = bus.b_addr; m_data = bus.b_data; m_last_b = 1'b1;
      end else if (!bus.wr_stall) begin
        m_vld = 1'b0;
      end
      if (bus.a_valid && bus.b_valid && !bus.wr_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.wr_stall = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Keep each valid request up until it transfers, within a cycle budget.
  task automatic drain();
    logic xa, xb;
    int   budget;
    budget = 40;
    while ((bus.a_valid || bus.b_valid) && budget > 0) begin
      @(negedge clk);
      xa = bus.a_valid && bus.a_ready;
      xb = bus.b_valid && bus.b_ready;
      step();
      if (xa) bus.a_valid = 1'b0;
      if (xb) bus.b_valid = 1'b0;
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 32'(1), 32'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] saved7;
    logic xa, xb;

    bus.a_valid = 1'b1; bus.a_addr = 3'd3; bus.a_data = 16'h1234;
    bus.b_valid = 1'b0; bus.b_addr = '0;   bus.b_data = '0;
    bus.wr_stall = 1'b0; bus.rd_addr = '0;
    step();
    @(negedge clk);
    chk("rst_a_ready", 32'(bus.a_ready), 32'(0));
    chk("rst_wr_en", 32'(bus.reg_wr_en), 32'(0));
    chk("rst_rd_pending", 32'(bus.rd_pending), 32'(0));
    chk("rst_wr_data", 32'(bus.reg_wr_data), 32'(0));
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("single_a_ready", 32'(bus.a_ready), 32'(1));
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("single_wr_en", 32'(bus.reg_wr_en), 32'h08);
    chk("single_wr_data", 32'(bus.reg_wr_data), 32'h1234);
    step(); step();
    chk("single_reg3", 32'(d_regs[3]), 32'h1234);

    // Tie from reset: A wins first, then alternation.
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 16'hAAAA;
    bus.b_valid = 1'b1; bus.b_addr = 3'd2; bus.b_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tie_a_ready", 32'(bus.a_ready), 32'(i % 2 == 0));
      chk("tie_b_ready", 32'(bus.b_ready), 32'(i % 2 == 1));
      step();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
`ifdef REGWR_ARBITER_CONFLICT_CNT_EN
    @(negedge clk);
    chk("tie_conflict_cnt", 32'(conflict_cnt), 32'd4);
`endif
    step(); step();

    // Same address: A then B, B's value remains.
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 3'd5; bus.a_data = 16'h0001;
    bus.b_valid = 1'b1; bus.b_addr = 3'd5; bus.b_data = 16'h0002;
    @(negedge clk);
    chk("same_a_first", 32'(bus.a_ready), 32'(1));
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("same_b_second", 32'(bus.b_ready), 32'(1));
    chk("same_first_data", 32'(bus.reg_wr_data), 32'h0001);
    step();
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("same_second_en", 32'(bus.reg_wr_en), 32'h20);
    chk("same_second_data", 32'(bus.reg_wr_data), 32'h0002);
    step(); step();
    chk("same_reg5", 32'(d_regs[5]), 32'h0002);

    // Stall with addr 6 held in the issue stage while both requesters wait.
    bus.a_valid = 1'b1; bus.a_addr = 3'd6; bus.a_data = 16'h6666;
    step();
    bus.a_addr = 3'd2; bus.a_data = 16'h2222;
    bus.b_valid = 1'b1; bus.b_addr = 3'd4; bus.b_data = 16'h4444;
    bus.wr_stall = 1'b1; bus.rd_addr = 3'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_wr_en", 32'(bus.reg_wr_en), 32'(0));
      chk("stall_a_ready", 32'(bus.a_ready), 32'(0));
      chk("stall_b_ready", 32'(bus.b_ready), 32'(0));
      chk("stall_rd_pending", 32'(bus.rd_pending), 32'(1));
      step();
    end
    bus.wr_stall = 1'b0;
    @(negedge clk);
    chk("stall_release_en", 32'(bus.reg_wr_en), 32'h40);
    chk("stall_release_data", 32'(bus.reg_wr_data), 32'h6666);
    drain();
    step(); step();
    chk("stall_reg6", 32'(d_regs[6]), 32'h6666);
    chk("stall_reg4", 32'(d_regs[4]), 32'h4444);
    chk("stall_reg2", 32'(d_regs[2]), 32'h2222);

    // Reset while a write to addr 7 is in the issue stage.
    saved7 = d_regs[7];
    bus.a_valid = 1'b1; bus.a_addr = 3'd7; bus.a_data = 16'h7777;
    step();
    bus.a_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_wr_en", 32'(bus.reg_wr_en), 32'(0));
    step();
    rst = 1'b1;
    step(); step();
    chk("midrst_reg7", 32'(d_regs[7]), 32'(saved7));

    // Randomized traffic with stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      xa = bus.a_valid && bus.a_ready;
      xb = bus.b_valid && bus.b_ready;
      step();
      if (!bus.a_valid || xa) begin
        bus.a_valid = ($urandom_range(1) == 1);
        bus.a_addr  = reg_addr_t'($urandom_range(N_REGS - 1));
        bus.a_data  = DATA_W'($urandom);
      end
      if (!bus.b_valid || xb) begin
        bus.b_valid = ($urandom_range(2) != 0);
        bus.b_addr  = reg_addr_t'($urandom_range(N_REGS - 1));
        bus.b_data  = DATA_W'($urandom);
      end
      bus.wr_stall = ($urandom_range(6) == 0);
      bus.rd_addr  = reg_addr_t'($urandom_range(N_REGS - 1));
      rst          = ($urandom_range(99) != 0);
    end
    rst = 1'b1; bus.wr_stall = 1'b0;
    drain();
    step(); step();

`ifdef REGWR_ARBITER_CONFLICT_CNT_EN
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int c = 0; c < 70000; c++) step();
    @(negedge clk);
    chk("sat_conflict_cnt", 32'(conflict_cnt), 32'hFFFF);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step(); step(); step();
`endif

    for (int i = 0; i < N_REGS; i++)
      chk($sformatf("final_reg%0d", i), 32'(d_regs[i]), 32'(m_regs[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regwr_arbiter.md
# regwr_arbiter

Write-port arbiter and sequencer for the 8 × 16-bit general register file built from `reg_16b` instances. Two requesters share the single register-file write port: A (pipeline writeback) and B (long-latency unit, e.g. multiply/divide). It grants one requester per cycle using round-robin priority and latches the winning write into a one-entry issue stage. It then drives the per-register one-hot `writeEn` lines and the shared `inputData` bus of the register file.

## Interface
Parameters:
- `N_REGS`, 8: number of registers, one `writeEn` each
- `DATA_W`, 16: register width
- `REG_AW`, 3: register address width, clog2(`N_REGS`)

Ports:
- `clk`, in, 1: single clock, rising edge
- `rst`, in, 1: synchronous, active-low reset (sampled on `clk`; 0 = reset)
- `a_valid`, in, 1: requester A has a write pending
- `a_addr`, in, `REG_AW`: destination register for A
- `a_data`, in, `DATA_W`: write data for A
- `a_ready`, out, 1: A's request is accepted this cycle
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same set of signals for requester B
- `wr_stall`, in, 1: freezes the issue stage and blocks all grants
- `reg_wr_en`, out, `N_REGS`: one-hot `writeEn` vector to the register file
- `reg_wr_data`, out, `DATA_W`: `inputData` to all registers
- `rd_addr`, in, `REG_AW`: read address, used for the in-flight check
- `rd_pending`, out, 1: a write to `rd_addr` sits in the issue stage
- `conflict_cnt`, out, 16: present only with the macro (see Configuration)

## Operation
- Handshake: a request transfers on a cycle where valid && ready. The requester must hold addr and data stable while valid && !ready, and must not drop valid before the transfer.
- Grant rules, evaluated combinationally:
  - Ready is 0 for both requesters while `wr_stall` = 1.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not granted most recently wins.
- `last_grant` register: updates to the winner on each transfer. Reset value is B, so A wins the first tie.
- Issue stage holds `iss_vld`, `iss_addr` and `iss_data`:
  - On a transfer, it loads the winner's addr and data and sets `iss_vld`.
  - With no transfer and no stall, it clears `iss_vld`.
  - While `wr_stall` = 1, it holds its contents.
- Write-port outputs: `reg_wr_en` = `iss_vld` && !`wr_stall` ? onehot(`iss_addr`) : 0. `reg_wr_data` = `iss_data`.
- Read check: `rd_pending` = `iss_vld` && (`iss_addr` == `rd_addr`). The read side uses this to stall or bypass.
- Same address from both requesters: the writes serialize in grant order, so the later grant holds the final value.
- Register 0 is not special; every address is writable.

## Timing
- Reset (`rst` = 0 at a clock edge) gives:
  - `iss_vld` = 0, `iss_addr` = 0, `iss_data` = 0, `last_grant` = B.
  - `reg_wr_en` = 0, `rd_pending` = 0, `conflict_cnt` = 0.
  - `a_ready` and `b_ready` are 0 during the reset cycle.
- Reset mid-operation: the pending issue-stage write is discarded and never reaches the register file.
- Latency: a transfer at edge N asserts `reg_wr_en` for the cycle after N. The register holds the new value after edge N+1.
- Throughput: one write per cycle. With back-to-back contention the grants alternate A, B, A, B.
- `wr_stall` rising while `iss_vld` = 1:
  - `reg_wr_en` drops in that same cycle.
  - The held write issues in the first cycle after `wr_stall` falls.
  - A new grant in that cycle overwrites the issue stage only after the held write has been presented for that cycle.
- Implementation note: because of this last rule, the issue stage loads from the grant only when not stalled, which is the same condition as the stage draining. No write is lost.

## Configuration
- `REGWR_ARBITER_CONFLICT_CNT_EN` defined:
  - Adds the `conflict_cnt` port, a 16-bit counter.
  - It increments on every cycle with `a_valid` && `b_valid` && !`wr_stall` && `rst`.
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `regwr_arbiter_pkg` holds:
  - Constants `N_REGS`, `DATA_W`, `REG_AW`.
  - Typedef `grant_e` with values `GRANT_A` and `GRANT_B`.
  - Typedef `reg_addr_t`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with inputs `req[1:0]`, `last`, `en` and output `gnt[1:0]`. It is purely combinational; the `last_grant` register stays in the top level.

## Test plan
- Reset then single write: after reset, A writes addr 3, data 16'h1234. Expect `reg_wr_en` = 8'b0000_1000 one cycle after the transfer and `reg_wr_data` = 16'h1234. Register 3 reads 16'h1234 after that.
- Tie: A (addr 1, 16'hAAAA) and B (addr 2, 16'h5555) both valid for 4 cycles. Grants alternate A, B, A, B; `conflict_cnt` = 4 when the macro is enabled.
- Same address: A (addr 5, 16'h0001) and B (addr 5, 16'h0002) valid together with `last_grant` = B. A issues first, then B; final register 5 = 16'h0002.
- Stall: hold `wr_stall` = 1 for 3 cycles while addr 6 is in the issue stage. `reg_wr_en` = 0 and both ready signals = 0 throughout; `rd_pending` = 1 for `rd_addr` = 6. The write issues the cycle after `wr_stall` = 0.
- Reset mid-flight: assert `rst` = 0 in the cycle a write to addr 7 sits in the issue stage. `reg_wr_en` stays 0 and register 7 is unchanged.
- Saturation (macro enabled): force contention for 70000 cycles. `conflict_cnt` ends at 16'hFFFF.
